mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Burst initiator for the single-port 1024x8 data memory. Accepts read/write burst commands over a valid/ready command channel, streams write bytes in and read bytes out over valid/ready data channels, and drives the memory's address, write-enable, write-data and read-enable pins while honouring the memory's registered-write and one-cycle-read timing. It sits between a byte-stream source (UART loader, debug port) and the memory, e.g. for preload and dump of program/data RAM.

## Interface
- ADDR_W, 10, memory address width; burst length field shares this width
- DATA_W, 8, byte width
- i_clk  in  1  clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_rnw  in  1  1 = read burst, 0 = write burst
- i_cmd_addr  in  ADDR_W  start address
- i_cmd_len  in  ADDR_W  beat count minus 1 (0 -> 1 beat, 1023 -> 1024 beats)
- i_wr_valid / o_wr_ready  in/out  1  write-data handshake
- i_wr_data  in  DATA_W  write byte
- o_rd_valid / i_rd_ready  out/in  1  read-data handshake
- o_rd_data  out  DATA_W  read byte
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle pulse at burst completion
- o_mem_addr  out  ADDR_W  to memory i_addr
- o_mem_we  out  1  to memory i_we
- o_mem_wdata  out  DATA_W  to memory i_wdata
- o_mem_re  out  1  to memory i_re
- i_mem_rdata  in  DATA_W  from memory o_rdata
- o_sum  out  DATA_W  running byte checksum (see Configuration)

## Operation
- States: IDLE, WR, WR_FLUSH, RD, RD_DRAIN.
- IDLE: o_cmd_ready=1; command accepted on i_cmd_valid&o_cmd_ready; address and remaining count loaded; go WR or RD.
- WR: o_wr_ready=1; each accepted beat registers o_mem_we=1, o_mem_addr, o_mem_wdata for exactly one cycle; address increments mod 2^ADDR_W (0x3FF -> 0x000). Cycles without a beat drive o_mem_we=0. After the last beat -> WR_FLUSH.
- WR_FLUSH: two cycles, memory port idle; o_done pulses in the second; then IDLE. Guarantees any following read sees the written data (memory commits the write one cycle after o_mem_we).
- RD: issue o_mem_re=1 with address when (buffered + in-flight) < 2; i_mem_rdata captured on the edge after the re cycle into a 2-entry output buffer. After the last issue -> RD_DRAIN.
- RD_DRAIN: wait until the buffer is empty and nothing is in flight; o_done pulses on the cycle of the last o_rd_valid&i_rd_ready; then IDLE.
- Read data order equals address order; no byte dropped or duplicated under any i_rd_ready pattern.
- o_mem_we and o_mem_re never asserted in the same cycle.
- o_busy = state != IDLE.

## Timing
- Reset values: o_cmd_ready=1, o_wr_ready=0, o_rd_valid=0, o_rd_data=0, o_busy=0, o_done=0, o_mem_addr=0, o_mem_we=0, o_mem_wdata=0, o_mem_re=0, o_sum=0; state IDLE, buffer empty.
- Command accepted at edge T -> WR/RD active from cycle T+1.
- Write beat accepted at edge N -> o_mem_we high in cycle N+1.
- o_mem_re high in cycle N -> byte in buffer, o_rd_valid high, in cycle N+2 earliest.
- Full-throughput read with i_rd_ready=1: one byte per cycle after a 2-cycle startup.
- Reset mid-burst: immediate return to reset values; partial burst discarded; no o_done.
- i_cmd_valid while busy: ignored (held by sender; o_cmd_ready=0).

## Configuration
- MEM_BURST_SUM_EN defined: o_sum = modulo-2^DATA_W sum of every byte transferred (write beats accepted, read bytes delivered) since the last command accept; cleared to 0 on accept.
- Not defined: o_sum tied to 0; no adder or register present.

## Structure
- Shared package: state encoding constants, ADDR_W/DATA_W defaults, WR_FLUSH length (2).
- One sub-module: mem_rd_skid, the 2-entry read-return buffer with occupancy/credit output.

## Test plan
- Write addr 0x010 len 2 bytes A1,B2,C3, then read addr 0x010 len 2 -> o_rd_data A1,B2,C3; one o_done per burst.
- Write addr 0x3FE len 3 bytes 11,22,33,44 -> o_mem_addr sequence 3FE,3FF,000,001; readback matches.
- Read len 7 with i_rd_ready low for 10 cycles -> at most 2 o_mem_re issued before release; all 8 bytes delivered in order.
- Write with i_wr_valid toggling every other cycle -> o_mem_we only in the cycle after each accepted beat, addresses contiguous.
- Assert i_nrst low mid-read -> all outputs at reset values next cycle; after release o_cmd_ready=1, no o_done.
- With MEM_BURST_SUM_EN: write bytes 01,02,FF -> o_sum=02 after burst; next command accept clears o_sum to 00.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// rtl/mem_burst_ctrl_pkg.sv - shared constants and state encoding for mem_burst_ctrl
// Purpose: default widths, write-flush length and the controller state type.
// Ports: none (package).
// Optional feature macro used by the top: MEM_BURST_SUM_EN.
package mem_burst_ctrl_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 8;
  localparam int WR_FLUSH_LEN = 2;
  localparam int FLUSH_W      = (WR_FLUSH_LEN > 1) ? $clog2(WR_FLUSH_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_WR_FLUSH = 3'd2,
    ST_RD       = 3'd3,
    ST_RD_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/mem_burst_ctrl_rd_skid.sv
// rtl/mem_burst_ctrl_rd_skid.sv - 2-entry read-return buffer (module mem_rd_skid)
// Purpose: holds bytes returned by the memory until the consumer takes them.
// Ports:
//   i_clk, i_nrst        clock, asynchronous active-low reset
//   i_push, i_push_data  byte arriving from the memory read port
//   i_pop                consumer takes the head byte (only while o_valid)
//   o_valid, o_data      head of buffer
//   o_count              occupancy 0..2, used by the issuer as credit
module mem_rd_skid
  import mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + {1'b0, i_push} - {1'b0, i_pop};
    if (i_pop) begin
      head_d = tail_q;
    end
    // The incoming byte lands in the first slot left free after this cycle's pop.
    if (i_push) begin
      if ((cnt_q - {1'b0, i_pop}) == 2'd0) begin
        head_d = i_push_data;
      end else begin
        tail_d = i_push_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = head_q;
  assign o_count = cnt_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst initiator for the single-port 1024x8 data memory
// Purpose: accepts read/write burst commands, streams bytes in/out and drives
//   the memory pins (registered write, one-cycle read latency).
// Ports:
//   i_clk, i_nrst                       clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_rnw, i_cmd_addr, i_cmd_len   command channel
//   i_wr_valid/o_wr_ready, i_wr_data    write byte stream
//   o_rd_valid/i_rd_ready, o_rd_data    read byte stream
//   o_busy, o_done                      status
//   o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re, i_mem_rdata   memory port
//   o_sum                               running byte checksum
// Optional feature: define MEM_BURST_SUM_EN to enable o_sum; otherwise it is 0.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rnw,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_sum
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic              rvld_q;

  logic              cmd_acc;
  logic              wr_beat;
  logic              pop;
  logic              rd_issue;
  logic [1:0]        rd_count;
  logic [2:0]        pending;

  assign cmd_acc = (state_q == ST_IDLE) && i_cmd_valid;
  assign wr_beat = (state_q == ST_WR) && i_wr_valid;
  assign pop     = o_rd_valid && i_rd_ready;

  // Buffered plus in-flight bytes, crediting the slot freed by this cycle's
  // pop; this lets a 2-entry buffer sustain one byte per cycle.
  assign pending  = {1'b0, rd_count} + {2'b0, rvld_q} - {2'b0, pop};
  assign rd_issue = (state_q == ST_RD) && (pending < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    flush_d     = flush_q;
    o_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          addr_d  = i_cmd_addr;
          rem_d   = i_cmd_len;
          state_d = i_cmd_rnw ? ST_RD : ST_WR;
        end
      end
      ST_WR: begin
        if (wr_beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = i_wr_data;
          addr_d      = addr_q + 1'b1;
          if (rem_q == '0) begin
            state_d = ST_WR_FLUSH;
            flush_d = '0;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      ST_WR_FLUSH: begin
        if (flush_q == FLUSH_W'(WR_FLUSH_LEN - 1)) begin
          o_done  = 1'b1;
          flush_d = '0;
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      ST_RD: begin
        if (rd_issue) begin
          addr_d = addr_q + 1'b1;
          if (rem_q == '0) begin
            state_d = ST_RD_DRAIN;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      ST_RD_DRAIN: begin
        if (pop && (rd_count == 2'd1) && !rvld_q) begin
          o_done  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      flush_q     <= '0;
      rvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      flush_q     <= flush_d;
      rvld_q      <= rd_issue;   // memory data is valid the cycle after re
    end
  end

  mem_rd_skid #(.DATA_W(DATA_W)) u_rd_skid (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_push      (rvld_q),
    .i_push_data (i_mem_rdata),
    .i_pop       (pop),
    .o_valid     (o_rd_valid),
    .o_data      (o_rd_data),
    .o_count     (rd_count)
  );

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_wr_ready  = (state_q == ST_WR);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_re    = rd_issue;
  // Reads issue combinationally from the live address; writes use the
  // registered beat address.
  assign o_mem_addr  = (state_q == ST_RD) ? addr_q : mem_addr_q;

`ifdef MEM_BURST_SUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (cmd_acc) begin
      sum_d = '0;
    end else if (wr_beat) begin
      sum_d = sum_q + i_wr_data;
    end else if (pop) begin
      sum_d = sum_q + o_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;
`else
  assign o_sum = '0;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

  logic       i_clk;
  logic       i_nrst;
  logic       i_cmd_valid, o_cmd_ready, i_cmd_rnw;
  logic [9:0] i_cmd_addr, i_cmd_len;
  logic       i_wr_valid, o_wr_ready;
  logic [7:0] i_wr_data;
  logic       o_rd_valid, i_rd_ready;
  logic [7:0] o_rd_data;
  logic       o_busy, o_done;
  logic [9:0] o_mem_addr;
  logic       o_mem_we, o_mem_re;
  logic [7:0] o_mem_wdata, i_mem_rdata, o_sum;

  mem_burst_ctrl dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rnw(i_cmd_rnw),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_done(o_done),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata), .o_sum(o_sum)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model: registered write, one-cycle registered read.
  logic [7:0] mem [0:1023];
  bit         mem_loaded = 1'b0;
  always @(posedge i_clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 8'(k ^ 'h5A);
      mem_loaded <= 1'b1;
    end else begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      if (o_mem_re) i_mem_rdata <= mem[o_mem_addr];
    end
  end

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       rnw;
    logic [9:0] addr;
    logic [9:0] len;
    logic [7:0] base;
    bit         gap;
    int         stall;
    bit         rnd;
  } vec_t;

  logic [7:0] ref_mem [0:1023];
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_bytes[$];
  logic [7:0] exp_sum;

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, done_cyc = 0, re_cnt = 0, acc_cyc = 0;
  bit prev_beat = 1'b0;
  wr_t mon_w;
  logic [7:0] mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: scoreboard empty", name);
  endtask

  // Scoreboard side: compares memory writes and delivered read bytes.
  always @(negedge i_clk) begin
    if (!i_nrst) begin
      prev_beat = 1'b0;
    end else begin
      if (o_mem_we || prev_beat) check("we_after_beat", 32'(o_mem_we), 32'(prev_beat));
      if (o_mem_we) begin
        if (exp_wr.size() == 0) fail_now("wr_unexpected");
        else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", 32'(o_mem_addr), 32'(mon_w.a));
          check("wr_data", 32'(o_mem_wdata), 32'(mon_w.d));
        end
      end
      if (o_mem_we && o_mem_re) check("we_re_overlap", 32'(o_mem_re), 32'd0);
      if (o_rd_valid && i_rd_ready) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected");
        else begin
          mon_b = exp_rd.pop_front();
          check("rd_data", 32'(o_rd_data), 32'(mon_b));
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_mem_re) re_cnt++;
      prev_beat = i_wr_valid && o_wr_ready;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"},
          32'({o_cmd_ready, o_wr_ready, o_rd_valid, o_busy, o_done, o_mem_we, o_mem_re}),
          32'b1000000);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_data"}, 32'({o_rd_data, o_mem_wdata, o_sum}), 32'd0);
  endtask

  task automatic run_burst(input vec_t v);
    int d0, re0, t;
    logic [7:0] b;
    d0 = done_cnt;
    check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_rnw   = v.rnw;
    i_cmd_addr  = v.addr;
    i_cmd_len   = v.len;
    i_rd_ready  = v.rnw && (v.stall == 0) && !v.rnd;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    acc_cyc = cyc;
    re0 = re_cnt;
    exp_sum = 8'h00;
    check("busy_after_acc", 32'({o_busy, o_cmd_ready}), 32'b10);
    check("sum_clear_on_acc", 32'(o_sum), 32'd0);
    if (!v.rnw) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        if (v.gap) begin
          i_wr_valid = 1'b0;
          @(posedge i_clk); #1;
        end
        b = wr_bytes.pop_front();
        i_wr_valid = 1'b1;
        i_wr_data  = b;
        exp_wr.push_back('{a: 10'(int'(v.addr) + i), d: b});
        ref_mem[10'(int'(v.addr) + i)] = b;
        exp_sum = exp_sum + b;
        t = 0;
        @(negedge i_clk);
        while (!o_wr_ready && t < 50) begin
          @(negedge i_clk);
          t++;
        end
        @(posedge i_clk); #1;
      end
      i_wr_valid = 1'b0;
    end else begin
      for (int i = 0; i <= int'(v.len); i++) begin
        b = ref_mem[10'(int'(v.addr) + i)];
        exp_rd.push_back(b);
        exp_sum = exp_sum + b;
      end
      if (v.stall > 0) begin
        i_cmd_valid = 1'b1;   // must be ignored while busy
        i_cmd_rnw   = 1'b0;
        repeat (v.stall) @(posedge i_clk);
        #1;
        check("stall_re_le2", 32'((re_cnt - re0) <= 2), 32'd1);
        check("stall_no_accept", 32'(o_busy), 32'd1);
        i_cmd_valid = 1'b0;
        i_rd_ready  = 1'b1;
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge i_clk); #1;
      if (v.rnd) i_rd_ready = 1'($urandom_range(0, 1));
      t++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    if (!v.gap && v.stall == 0 && !v.rnd)
      check("done_latency", 32'(done_cyc - acc_cyc), 32'(int'(v.len) + 2));
    repeat (3) @(posedge i_clk);
    #1;
    i_rd_ready = 1'b0;
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("queues_empty", 32'(exp_wr.size() + exp_rd.size()), 32'd0);
`ifdef MEM_BURST_SUM_EN
    check("sum", 32'(o_sum), 32'(exp_sum));
`else
    check("sum_off", 32'(o_sum), 32'd0);
`endif
  endtask

  vec_t tbl[10];

  initial begin
    int d0;
    i_nrst = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_rnw = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 8'(k ^ 'h5A);

    //          rnw   addr     len       base   gap   stall rnd
    tbl[0] = '{1'b0, 10'h010, 10'd2,    8'hA1, 1'b0, 0,  1'b0};
    tbl[1] = '{1'b1, 10'h010, 10'd2,    8'h00, 1'b0, 0,  1'b0};
    tbl[2] = '{1'b0, 10'h3FE, 10'd3,    8'h11, 1'b0, 0,  1'b0};
    tbl[3] = '{1'b1, 10'h3FE, 10'd3,    8'h00, 1'b0, 0,  1'b0};
    tbl[4] = '{1'b0, 10'h100, 10'd7,    8'h05, 1'b1, 0,  1'b0};
    tbl[5] = '{1'b1, 10'h100, 10'd7,    8'h00, 1'b0, 10, 1'b0};
    tbl[6] = '{1'b1, 10'h3F0, 10'd31,   8'h00, 1'b0, 0,  1'b1};
    tbl[7] = '{1'b1, 10'h000, 10'd0,    8'h00, 1'b0, 0,  1'b0};
    tbl[8] = '{1'b0, 10'h020, 10'd0,    8'h7E, 1'b0, 0,  1'b0};
    tbl[9] = '{1'b1, 10'h000, 10'd1023, 8'h00, 1'b0, 0,  1'b0};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_vals("reset");
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    @(posedge i_clk); #1;

    for (int v = 0; v < 10; v++) begin
      if (!tbl[v].rnw)
        for (int i = 0; i <= int'(tbl[v].len); i++)
          wr_bytes.push_back(8'(tbl[v].base + 8'(i * 17)));
      run_burst(tbl[v]);
    end

    // Checksum corner: 01+02+FF wraps to 02; the next accept clears it.
    wr_bytes.push_back(8'h01);
    wr_bytes.push_back(8'h02);
    wr_bytes.push_back(8'hFF);
    run_burst('{1'b0, 10'h200, 10'd2, 8'h00, 1'b0, 0, 1'b0});
`ifdef MEM_BURST_SUM_EN
    check("sum_wrap", 32'(o_sum), 32'h02);
`endif
    run_burst('{1'b1, 10'h200, 10'd2, 8'h00, 1'b0, 0, 1'b0});

    // Reset in the middle of a read burst.
    d0 = done_cnt;
    i_cmd_valid = 1'b1; i_cmd_rnw = 1'b1; i_cmd_addr = 10'h000; i_cmd_len = 10'd20;
    i_rd_ready = 1'b1;
    for (int i = 0; i <= 20; i++) exp_rd.push_back(ref_mem[i]);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_nrst = 1'b0;
    @(negedge i_clk);
    check_reset_vals("midrst");
    exp_rd.delete();
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    @(negedge i_clk);
    check("rst_cmd_ready", 32'({o_cmd_ready, o_busy}), 32'b10);
    repeat (10) @(posedge i_clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    i_rd_ready = 1'b0;

    // The memory still holds earlier writes after the aborted burst.
    run_burst(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
